shared_op_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one two-operand async_operator-style unit (e.g. a single "mul") among num_req requesters.
- Requester-facing ports use the existing req/ack handshake: requester holds a level req, arbiter answers with a one-cycle ack plus result.
- Unit-facing port is the consumer side of the same handshake.
- Sits inside an arf between dataflow nodes and a shared datapath resource.

---
 rtl/shared_op_arbiter_pkg.sv | 19 +
 rtl/shared_op_arbiter_rr_pick.sv | 36 +++
 rtl/shared_op_arbiter.sv | 124 ++++++++++++
 tb/tb_shared_op_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_op_arbiter_pkg.sv
// Shared definitions for the round-robin operator arbiter: FSM encoding and
// the elaboration-time legality check on the requester count and grant width.
package shared_op_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int unsigned MIN_REQ = 2;
    localparam int unsigned MAX_REQ = 16;

    function automatic bit params_legal(input int unsigned n, input int unsigned w);
        return (n >= MIN_REQ) && (n <= MAX_REQ) && (w < 32) && ((32'd1 << w) >= n);
    endfunction

endpackage

// File: rtl/shared_op_arbiter_rr_pick.sv
// Round-robin pick: lowest set request at or above the pointer, otherwise the
// lowest set request overall (the wrapped search).
module rr_pick
    import shared_op_arbiter_pkg::*;
#(
    parameter int unsigned num_req  = 4,
    parameter int unsigned id_width = 2
) (
    input  logic [num_req-1:0]  req_i,
    input  logic [id_width-1:0] ptr_i,
    output logic                found_o,
    output logic [id_width-1:0] idx_o
);

    logic hi_found;

    always_comb begin
        found_o  = 1'b0;
        hi_found = 1'b0;
        idx_o    = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            if (req_i[i] && !found_o) begin
                found_o = 1'b1;
                idx_o   = id_width'(i);
            end
        end
        // A hit at or after the pointer overrides the wrapped candidate.
        for (int unsigned i = 0; i < num_req; i++) begin
            if (req_i[i] && (i >= 32'(ptr_i)) && !hi_found) begin
                hi_found = 1'b1;
                idx_o    = id_width'(i);
            end
        end
    end

endmodule

// File: rtl/shared_op_arbiter.sv
// Round-robin sequencer sharing one two-operand unit among num_req requesters
// over level-req / one-cycle-ack handshakes on both sides.
module shared_op_arbiter
    import shared_op_arbiter_pkg::*;
#(
    parameter int unsigned num_req    = 4,
    parameter int unsigned data_width = 32,
    parameter int unsigned id_width   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req_in,
    output logic [num_req-1:0]            ack_in,
    input  logic [num_req*data_width-1:0] din_a,
    input  logic [num_req*data_width-1:0] din_b,
    output logic [data_width-1:0]         dout,
    output logic                          op_req,
    input  logic                          op_ack,
    output logic [data_width-1:0]         op_a,
    output logic [data_width-1:0]         op_b,
    input  logic [data_width-1:0]         op_res,
    output logic [id_width-1:0]           grant_id,
    output logic                          busy,
    output logic [31:0]                   count
);

    if (!params_legal(num_req, id_width)) begin : g_param_check
        $error("shared_op_arbiter: num_req must be 2..16 and fit in id_width bits");
    end

    state_e                  state_q;
    logic [id_width-1:0]     rr_ptr_q;
    logic [id_width-1:0]     grant_q;
    logic [num_req-1:0]      ack_q;
    logic [data_width-1:0]   dout_q;
    logic                    op_req_q;
    logic [data_width-1:0]   op_a_q;
    logic [data_width-1:0]   op_b_q;
    logic [31:0]             count_q;

    logic                    pick_found;
    logic [id_width-1:0]     pick_idx;
    logic [data_width-1:0]   a_sel_d;
    logic [data_width-1:0]   b_sel_d;
    logic [num_req-1:0]      ack_onehot_d;
    logic [id_width-1:0]     rr_next_d;

    rr_pick #(
        .num_req  (num_req),
        .id_width (id_width)
    ) u_rr_pick (
        .req_i   (req_in),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        a_sel_d      = '0;
        b_sel_d      = '0;
        ack_onehot_d = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            if (pick_idx == id_width'(i)) begin
                a_sel_d = din_a[i*data_width +: data_width];
                b_sel_d = din_b[i*data_width +: data_width];
            end
            ack_onehot_d[i] = (grant_q == id_width'(i));
        end
        rr_next_d = (grant_q == id_width'(num_req - 1)) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            dout_q   <= '0;
            op_req_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_q  <= pick_idx;
                        op_a_q   <= a_sel_d;
                        op_b_q   <= b_sel_d;
                        op_req_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_ack) begin
                        op_req_q <= 1'b0;
                        dout_q   <= op_res;
                        ack_q    <= ack_onehot_d;
                        count_q  <= count_q + 32'd1;
                        rr_ptr_q <= rr_next_d;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ack_q   <= '0;
                    state_q <= ST_HOLD;
                end
                // One idle-ish cycle so the requester's registered req can fall.
                ST_HOLD: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack_in   = ack_q;
    assign dout     = dout_q;
    assign op_req   = op_req_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign count    = count_q;

endmodule

// File: tb/tb_shared_op_arbiter.sv
// Directed bench for shared_op_arbiter: a behavioural shared unit answers op_req
// after a programmable latency; expected results are hand-computed constants.
module tb_shared_op_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_in;
    logic [N-1:0]      ack_in;
    logic [N*DW-1:0]   din_a;
    logic [N*DW-1:0]   din_b;
    logic [DW-1:0]     dout;
    logic              op_req;
    logic              op_ack;
    logic [DW-1:0]     op_a;
    logic [DW-1:0]     op_b;
    logic [DW-1:0]     op_res;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic [31:0]       count;

    logic              unit_ack;
    logic [DW-1:0]     unit_res;
    logic              force_ack;
    logic [DW-1:0]     force_res;
    int unsigned       unit_lat;
    logic              unit_mul;

    int checks;
    int errors;

    assign op_ack = unit_ack | force_ack;
    assign op_res = force_ack ? force_res : unit_res;

    shared_op_arbiter #(
        .num_req    (N),
        .data_width (DW),
        .id_width   (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .ack_in   (ack_in),
        .din_a    (din_a),
        .din_b    (din_b),
        .dout     (dout),
        .op_req   (op_req),
        .op_ack   (op_ack),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_res   (op_res),
        .grant_id (grant_id),
        .busy     (busy),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared unit: raises op_ack for one cycle once op_req has been high unit_lat+1 cycles.
    initial begin
        int unsigned ucnt;
        unit_ack = 1'b0;
        unit_res = '0;
        ucnt     = 0;
        forever begin
            @(negedge clk);
            if (unit_ack) begin
                unit_ack = 1'b0;
                ucnt     = 0;
            end else if (op_req) begin
                ucnt++;
                if (ucnt == unit_lat + 1) begin
                    unit_ack = 1'b1;
                    unit_res = unit_mul ? op_a * op_b : op_a + op_b;
                    ucnt     = 0;
                end
            end else begin
                ucnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_opd(input int unsigned i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        din_a[i*DW +: DW] = a;
        din_b[i*DW +: DW] = b;
    endtask

    task automatic wait_ack(input string tag, input logic [N-1:0] exp, output int cyc);
        logic [N-1:0] seen;
        seen = '0;
        cyc  = 0;
        while (seen == '0 && cyc < 60) begin
            tick();
            cyc++;
            seen = ack_in;
        end
        check_eq(tag, 32'(seen), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [N-1:0] exp_oh;
        logic [31:0]  prod [N];

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_in    = '0;
        din_a     = '0;
        din_b     = '0;
        force_ack = 1'b0;
        force_res = '0;
        unit_lat  = 1;
        unit_mul  = 1'b1;

        // Reset state
        repeat (2) tick();
        check_eq("rst_ack",   32'(ack_in),   32'd0);
        check_eq("rst_opreq", 32'(op_req),   32'd0);
        check_eq("rst_dout",  dout,          32'd0);
        check_eq("rst_opa",   op_a,          32'd0);
        check_eq("rst_opb",   op_b,          32'd0);
        check_eq("rst_gid",   32'(grant_id), 32'd0);
        check_eq("rst_busy",  32'(busy),     32'd0);
        check_eq("rst_count", count,         32'd0);
        rst = 1'b0;

        // Single request, mul unit, op_ack one cycle after op_req
        set_opd(2, 7, 6);
        unit_mul = 1'b1;
        unit_lat = 1;
        req_in   = 4'b0100;
        tick();
        check_eq("t1_opreq", 32'(op_req),   32'd1);
        check_eq("t1_opa",   op_a,          32'd7);
        check_eq("t1_opb",   op_b,          32'd6);
        check_eq("t1_gid",   32'(grant_id), 32'd2);
        check_eq("t1_busy",  32'(busy),     32'd1);
        wait_ack("t1_ack", 4'b0100, cyc);
        check_eq("t1_latency", 32'(cyc), 32'd2);
        check_eq("t1_dout",  dout,  32'd42);
        check_eq("t1_count", count, 32'd1);
        req_in = '0;
        tick();
        check_eq("t1_ack_width", 32'(ack_in), 32'd0);
        wait_idle("t1_idle");
        check_eq("t1_gid_hold", 32'(grant_id), 32'd2);
        check_eq("t1_dout_hold", dout, 32'd42);

        // Round-robin pointer: serve 0 alone, then 3 wins over 0
        set_opd(0, 2, 3);
        set_opd(3, 4, 5);
        req_in = 4'b0001;
        wait_ack("rr_setup", 4'b0001, cyc);
        check_eq("rr_setup_dout", dout, 32'd6);
        req_in = '0;
        wait_idle("rr_idle0");
        req_in = 4'b1001;
        wait_ack("rr_first", 4'b1000, cyc);
        check_eq("rr_first_dout", dout, 32'd20);
        req_in[3] = 1'b0;
        wait_ack("rr_second", 4'b0001, cyc);
        check_eq("rr_second_dout", dout, 32'd6);
        req_in = '0;
        wait_idle("rr_idle1");
        check_eq("rr_count", count, 32'd4);

        // Spurious op_ack in IDLE
        force_res = 999;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check_eq("sp_idle_ack",   32'(ack_in), 32'd0);
        check_eq("sp_idle_dout",  dout,        32'd6);
        tick();
        check_eq("sp_idle_count", count,       32'd4);
        check_eq("sp_idle_busy",  32'(busy),   32'd0);

        // Spurious op_ack during HOLD
        set_opd(2, 3, 4);
        req_in = 4'b0100;
        wait_ack("sp_hold_serve", 4'b0100, cyc);
        check_eq("sp_hold_serve_dout", dout, 32'd12);
        req_in = '0;
        tick();
        force_res = 123;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check_eq("sp_hold_ack",   32'(ack_in), 32'd0);
        check_eq("sp_hold_dout",  dout,        32'd12);
        tick();
        check_eq("sp_hold_count", count,       32'd5);
        check_eq("sp_hold_busy",  32'(busy),   32'd0);

        // Operand change after grant does not reach op_a
        set_opd(1, 5, 3);
        unit_mul = 1'b0;
        unit_lat = 3;
        req_in   = 4'b0010;
        tick();
        check_eq("oc_gid", 32'(grant_id), 32'd1);
        check_eq("oc_opa", op_a, 32'd5);
        set_opd(1, 9, 3);
        tick();
        check_eq("oc_opa_held", op_a, 32'd5);
        wait_ack("oc_ack", 4'b0010, cyc);
        check_eq("oc_dout", dout, 32'd8);
        req_in = '0;
        wait_idle("oc_idle");
        check_eq("oc_count", count, 32'd6);

        // Reset mid-ISSUE: op_req drops immediately, pending request re-served
        set_opd(3, 11, 2);
        unit_lat = 4;
        req_in   = 4'b1000;
        tick();
        check_eq("rm_opreq_before", 32'(op_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rm_opreq_async", 32'(op_req), 32'd0);
        check_eq("rm_busy_async",  32'(busy),   32'd0);
        check_eq("rm_count_async", count,       32'd0);
        tick();
        force_res = 77;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check_eq("rm_ack_in_rst", 32'(ack_in), 32'd0);
        check_eq("rm_dout_in_rst", dout, 32'd0);
        rst = 1'b0;
        wait_ack("rm_reserve", 4'b1000, cyc);
        check_eq("rm_dout",  dout,          32'd13);
        check_eq("rm_count", count,         32'd1);
        check_eq("rm_gid",   32'(grant_id), 32'd3);
        req_in = '0;
        wait_idle("rm_idle");

        // All requesters continuously active, latency 3: grants 0,1,2,3,0,1
        do_reset();
        for (int unsigned i = 0; i < N; i++) begin
            set_opd(i, i + 1, 10 + i);
        end
        prod[0] = 10;
        prod[1] = 22;
        prod[2] = 36;
        prod[3] = 52;
        unit_mul = 1'b1;
        unit_lat = 3;
        req_in   = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            wait_ack("fair_ack", exp_oh, cyc);
            check_eq("fair_gid",  32'(grant_id), 32'(k % 4));
            check_eq("fair_dout", dout,          prod[k % 4]);
            tick();
            check_eq("fair_ack_width", 32'(ack_in), 32'd0);
        end
        req_in = '0;
        wait_idle("fair_idle");
        check_eq("fair_count", count, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
